// File: rtl/swervolf_flash_pkg.sv
// ============================================================================
// Module : swervolf_flash_pkg
// Brief  : Shared constants and FSM state type for the SPI flash reader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swervolf_flash_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         ADDR_BITS = 24;
   localparam int         CMD_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR    = 3'd2,
      DATA    = 3'd3,
      CS_HOLD = 3'd4,
      CS_GAP  = 3'd5
   } state_e;

endpackage

`default_nettype wire

// File: rtl/swervolf_spi_clkgen.sv
// ============================================================================
// Module : swervolf_spi_clkgen
// Brief  : SPI mode-0 clock generator with edge strobes, enable and stall.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swervolf_spi_clkgen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_en,
   input  logic i_stall,
   output logic o_sclk,
   output logic o_rise_stb,
   output logic o_fall_stb
);

   localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       w_tick;
   logic       w_hold;

   assign w_tick = (cnt_q == TICK_LAST);
   // A stall only freezes the low phase, so SCLK can never be parked high.
   assign w_hold = i_stall && !sclk_q;

   assign o_rise_stb = i_en && !w_hold && w_tick && !sclk_q;
   assign o_fall_stb = i_en && w_tick && sclk_q;
   assign o_sclk     = sclk_q;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!i_en) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (!w_hold) begin
         if (w_tick) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/swervolf_flash_reader.sv
// ============================================================================
// Module : swervolf_flash_reader
// Brief  : SPI flash READ (0x03) sequencer streaming bytes over valid/ready.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swervolf_flash_reader
   import swervolf_flash_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_start,
   input  logic [23:0]      i_addr,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_aborted,
   output logic [7:0]       o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_flash_sclk,
   output logic             o_flash_cs_n,
   output logic             o_flash_mosi,
   input  logic             i_flash_miso
);

   localparam logic [5:0]       CMD_LAST  = 6'(CMD_BITS - 1);
   localparam logic [5:0]       ADDR_LAST = 6'(ADDR_BITS - 1);
   localparam logic [5:0]       BYTE_LAST = 6'd7;
   localparam logic [8:0]       HOLD_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0]       GAP_LAST  = 9'(2 * CLK_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   state_e           state_q, state_d;
   logic             cs_n_q, cs_n_d;
   logic [31:0]      tx_q, tx_d;
   logic [6:0]       rx_q, rx_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [5:0]       bitcnt_q, bitcnt_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [8:0]       wcnt_q, wcnt_d;
   logic             abort_q, abort_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             sample_q;

   logic w_sclk, w_rise, w_fall;
   logic w_active, w_abort, w_drain, w_stall;

   assign w_active = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
   assign w_abort  = i_abort && (state_q != IDLE);
   assign w_drain  = (state_q == DATA) && (rem_q == '0);
   // Hold the byte-completing rise while the previous byte is still unclaimed;
   // once all bytes are in, park SCLK low until the last one is taken.
   assign w_stall  = w_drain ||
                     ((state_q == DATA) && (bitcnt_q == BYTE_LAST) && valid_q && !i_ready);

   swervolf_spi_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .clk        (clk),
      .rstn       (rstn),
      .i_en       (w_active && !i_abort),
      .i_stall    (w_stall),
      .o_sclk     (w_sclk),
      .o_rise_stb (w_rise),
      .o_fall_stb (w_fall)
   );

   always_comb begin
      state_d   = state_q;
      cs_n_d    = cs_n_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      data_d    = data_q;
      valid_d   = valid_q;
      bitcnt_d  = bitcnt_q;
      rem_d     = rem_q;
      wcnt_d    = wcnt_q;
      abort_d   = abort_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      if (valid_q && i_ready) valid_d = 1'b0;
      if (w_fall)             tx_d    = {tx_q[30:0], 1'b0};

      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (i_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = CMD;
                  cs_n_d   = 1'b0;
                  tx_d     = {CMD_READ, i_addr};
                  rem_d    = i_len;
                  bitcnt_d = '0;
                  abort_d  = 1'b0;
               end
            end
         end
         CMD: begin
            if (sample_q) begin
               if (bitcnt_q == CMD_LAST) begin
                  state_d  = ADDR;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + 6'd1;
               end
            end
         end
         ADDR: begin
            if (sample_q) begin
               if (bitcnt_q == ADDR_LAST) begin
                  state_d  = DATA;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + 6'd1;
               end
            end
         end
         DATA: begin
            if (sample_q) begin
               rx_d = {rx_q[5:0], i_flash_miso};
               if (bitcnt_q == BYTE_LAST) begin
                  bitcnt_d = '0;
                  data_d   = {rx_q, i_flash_miso};
                  valid_d  = 1'b1;
                  rem_d    = rem_q - LEN_ONE;
               end else begin
                  bitcnt_d = bitcnt_q + 6'd1;
               end
            end else if (w_drain && !w_sclk && (!valid_q || i_ready)) begin
               state_d = CS_HOLD;
               wcnt_d  = '0;
            end
         end
         CS_HOLD: begin
            if (wcnt_q == HOLD_LAST) begin
               state_d = CS_GAP;
               cs_n_d  = 1'b1;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 9'd1;
            end
         end
         CS_GAP: begin
            if (wcnt_q == GAP_LAST) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               aborted_d = abort_q;
            end else begin
               wcnt_d = wcnt_q + 9'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (w_abort) begin
         state_d = CS_HOLD;
         wcnt_d  = '0;
         valid_d = 1'b0;
         abort_d = 1'b1;
         tx_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cs_n_q    <= 1'b1;
         tx_q      <= '0;
         rx_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         bitcnt_q  <= '0;
         rem_q     <= '0;
         wcnt_q    <= '0;
         abort_q   <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         sample_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cs_n_q    <= cs_n_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         bitcnt_q  <= bitcnt_d;
         rem_q     <= rem_d;
         wcnt_q    <= wcnt_d;
         abort_q   <= abort_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         sample_q  <= w_rise;
      end
   end

   assign o_busy       = (state_q != IDLE);
   assign o_done       = done_q;
   assign o_aborted    = aborted_q;
   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_flash_sclk = w_sclk;
   assign o_flash_cs_n = cs_n_q;
   assign o_flash_mosi = tx_q[31];

endmodule

`default_nettype wire

// File: tb/tb_swervolf_flash_reader.sv
// ============================================================================
// Module : tb_swervolf_flash_reader
// Brief  : Directed self-checking bench for swervolf_flash_reader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_swervolf_flash_reader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_start;
   logic [23:0] i_addr;
   logic [15:0] i_len;
   logic        i_abort;
   logic        o_busy, o_done, o_aborted;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_flash_sclk, o_flash_cs_n, o_flash_mosi;
   logic        i_flash_miso = 1'b0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int         mon_valid, mon_sclk, mon_cs, mon_done, mon_nvalid;
   logic [7:0] mon_data;
   logic       mon_ab;

   swervolf_flash_reader #(
      .CLK_DIV (2),
      .LEN_W   (16)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_start      (i_start),
      .i_addr       (i_addr),
      .i_len        (i_len),
      .i_abort      (i_abort),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_aborted    (o_aborted),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_flash_sclk (o_flash_sclk),
      .o_flash_cs_n (o_flash_cs_n),
      .o_flash_mosi (o_flash_mosi),
      .i_flash_miso (i_flash_miso)
   );

   always #5 clk = ~clk;

   // Flash contents: 0x100 holds 0xA5, everything else is addr[7:0]^0x3C.
   function automatic logic [7:0] fbyte(input logic [23:0] a);
      return (a == 24'h000100) ? 8'hA5 : (a[7:0] ^ 8'h3C);
   endfunction

   function automatic logic mbit(input logic [23:0] a, input int idx);
      logic [7:0] b;
      b = fbyte(a + 24'(idx / 8));
      return b[7 - (idx % 8)];
   endfunction

   // Mode-0 flash model: samples MOSI on SCLK rise, shifts MISO on SCLK fall.
   logic [31:0] m_sh    = '0;
   int          m_bit   = 0;
   logic        m_cs_q  = 1'b1;
   logic        m_sck_q = 1'b0;

   always @(posedge clk) begin
      if (!o_flash_cs_n && m_cs_q) begin
         m_bit <= 0;
      end else if (!o_flash_cs_n && o_flash_sclk && !m_sck_q) begin
         if (m_bit < 32) m_sh <= {m_sh[30:0], o_flash_mosi};
         m_bit <= m_bit + 1;
      end else if (!o_flash_cs_n && !o_flash_sclk && m_sck_q && m_bit >= 32) begin
         i_flash_miso <= mbit(m_sh[23:0], m_bit - 32);
      end
      m_cs_q  <= o_flash_cs_n;
      m_sck_q <= o_flash_sclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // The start is sampled at the end of cycle 0; returns in cycle 1.
   task automatic start_job(input logic [23:0] a, input logic [15:0] n);
      i_start = 1'b1;
      i_addr  = a;
      i_len   = n;
      cyc     = 0;
      tick();
      i_start = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      mon_valid  = -1;
      mon_sclk   = -1;
      mon_cs     = -1;
      mon_done   = -1;
      mon_nvalid = 0;
      mon_data   = '0;
      mon_ab     = 1'b0;
      while (cyc < budget) begin
         if (o_valid) begin
            if (mon_valid < 0) begin
               mon_valid = cyc;
               mon_data  = o_data;
            end
            mon_nvalid++;
         end
         if (o_flash_sclk && mon_sclk < 0) mon_sclk = cyc;
         if (o_flash_cs_n && mon_cs < 0)   mon_cs   = cyc;
         if (o_done) begin
            mon_done = cyc;
            mon_ab   = o_aborted;
            break;
         end
         tick();
      end
   endtask

   initial begin
      int         nb;
      logic       hi, csh, seen_v;
      logic [7:0] d0;

      rstn    = 1'b0;
      i_start = 1'b0;
      i_addr  = '0;
      i_len   = '0;
      i_abort = 1'b0;
      i_ready = 1'b1;
      tick(); tick(); tick();

      // Reset state
      chk("rst_cs_n",  o_flash_cs_n, 1);
      chk("rst_sclk",  o_flash_sclk, 0);
      chk("rst_mosi",  o_flash_mosi, 0);
      chk("rst_busy",  o_busy, 0);
      chk("rst_done",  o_done, 0);
      chk("rst_abtd",  o_aborted, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_data",  o_data, 0);
      rstn = 1'b1;
      tick();

      // Abort while idle does nothing
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      tick();
      chk("idle_abort_busy", o_busy, 0);
      chk("idle_abort_done", o_done, 0);

      // Single byte read at 0x100
      start_job(24'h000100, 16'd1);
      chk("t1_cs_fall", o_flash_cs_n, 0);
      chk("t1_mosi0",   o_flash_mosi, 0);
      chk("t1_busy",    o_busy, 1);
      run_to_done(400);
      chk("t1_first_rise", mon_sclk, 3);
      chk("t1_valid_cyc",  mon_valid, 160);
      chk("t1_data",       mon_data, 8'hA5);
      chk("t1_nvalid",     mon_nvalid, 1);
      chk("t1_cs_rise",    mon_cs, 164);
      chk("t1_done_cyc",   mon_done, 168);
      chk("t1_aborted",    mon_ab, 0);
      chk("t1_mosi_cmd",   m_sh[31:24], 8'h03);
      chk("t1_mosi_addr",  m_sh[23:0], 24'h000100);
      tick();
      chk("t1_done_pulse", o_done, 0);
      chk("t1_busy_end",   o_busy, 0);

      // Four bytes with a 50-cycle consumer stall per byte
      i_ready = 1'b0;
      start_job(24'h000000, 16'd4);
      nb = 0;
      while (nb < 4 && cyc < 3000) begin
         if (o_valid) begin
            chk("t2_data", o_data, 8'h3C + 8'(nb));
            d0  = o_data;
            hi  = 1'b0;
            csh = 1'b0;
            for (int w = 0; w < 50; w++) begin
               tick();
               if (w >= 35 && o_flash_sclk) hi = 1'b1;
               if (o_flash_cs_n) csh = 1'b1;
            end
            chk("t2_sclk_frozen", hi, 0);
            chk("t2_cs_low", csh, 0);
            chk("t2_hold", {o_valid, o_data}, {1'b1, d0});
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            nb++;
         end else begin
            tick();
         end
      end
      chk("t2_count", nb, 4);
      run_to_done(3000);
      chk("t2_no_extra", mon_nvalid, 0);
      chk("t2_done_seen", (mon_done >= 0), 1);
      chk("t2_mosi_addr", m_sh[23:0], 24'h000000);
      i_ready = 1'b1;
      tick();

      // Zero-length job
      start_job(24'h000100, 16'd0);
      chk("t3_done", o_done, 1);
      chk("t3_busy", o_busy, 0);
      chk("t3_cs",   o_flash_cs_n, 1);
      tick();
      chk("t3_done_end", o_done, 0);
      chk("t3_cs_end",   o_flash_cs_n, 1);

      // Abort during address phase at cycle 60
      start_job(24'h000040, 16'd2);
      seen_v = 1'b0;
      while (cyc < 60) begin
         if (o_valid) seen_v = 1'b1;
         tick();
      end
      chk("t4_sclk_pre", o_flash_sclk, 1);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("t4_sclk_low", o_flash_sclk, 0);
      chk("t4_cs_61",    o_flash_cs_n, 0);
      chk("t4_busy",     o_busy, 1);
      tick();
      chk("t4_cs_62", o_flash_cs_n, 0);
      tick();
      chk("t4_cs_63", o_flash_cs_n, 1);
      run_to_done(200);
      chk("t4_done_cyc", mon_done, 67);
      chk("t4_aborted",  mon_ab, 1);
      chk("t4_no_valid", seen_v | (mon_nvalid != 0), 0);
      tick();

      // Start while busy is ignored; next job only after done
      start_job(24'h000100, 16'd1);
      while (cyc < 20) tick();
      i_start = 1'b1;
      i_addr  = 24'h000002;
      i_len   = 16'd1;
      tick();
      i_start = 1'b0;
      run_to_done(400);
      chk("t5_a_data",  mon_data, 8'hA5);
      chk("t5_a_done",  mon_done, 168);
      chk("t5_a_n",     mon_nvalid, 1);
      chk("t5_a_addr",  m_sh[23:0], 24'h000100);
      chk("t5_gap",     mon_done - mon_cs + 1, 5);
      start_job(24'h000002, 16'd1);
      chk("t5_b_cs", o_flash_cs_n, 0);
      run_to_done(400);
      chk("t5_b_valid", mon_valid, 160);
      chk("t5_b_data",  mon_data, 8'h3E);
      chk("t5_b_addr",  m_sh[23:0], 24'h000002);
      tick();

      // Asynchronous reset mid-data, then a clean job
      i_ready = 1'b0;
      start_job(24'h000100, 16'd2);
      while (cyc < 167) tick();
      chk("t6_pre_valid", o_valid, 1);
      chk("t6_pre_sclk",  o_flash_sclk, 1);
      rstn = 1'b0;
      #1;
      chk("t6_cs",    o_flash_cs_n, 1);
      chk("t6_sclk",  o_flash_sclk, 0);
      chk("t6_valid", o_valid, 0);
      chk("t6_busy",  o_busy, 0);
      tick();
      rstn    = 1'b1;
      i_ready = 1'b1;
      tick();
      start_job(24'h000100, 16'd1);
      run_to_done(400);
      chk("t6_valid_cyc", mon_valid, 160);
      chk("t6_data",      mon_data, 8'hA5);
      chk("t6_done_cyc",  mon_done, 168);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/swervolf_flash_reader.md
Name: swervolf_flash_reader

Overview:
- SPI flash read sequencer for the SweRVolf boot path.
- Accepts a job (24-bit flash address, byte count) and drives SPI mode 0 with the READ command (0x03) plus a 3-byte address.
- Streams returned bytes out through a valid/ready interface, so a loader can copy a flash image into RAM without software bit-banging.
- Sits between the boot-copy engine and the o_flash_* pins of swervolf_core; talks directly to the s25fl128s-class flash.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk cycles (legal range 1..255).
- LEN_W, 16, width of the byte-count input.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_start  in  1  job request, sampled only in IDLE
- i_addr  in  24  flash byte address, captured on an accepted start
- i_len  in  LEN_W  bytes to read, captured on an accepted start
- i_abort  in  1  terminate the current job
- o_busy  out  1  job in progress (high from the cycle after start until the done pulse)
- o_done  out  1  one-cycle pulse at job end
- o_aborted  out  1  qualifies o_done; high when the job ended by abort
- o_data  out  8  read byte, MSB first off the wire
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts o_data
- o_flash_sclk  out  1  SPI clock
- o_flash_cs_n  out  1  chip select, active low
- o_flash_mosi  out  1  SPI data to flash
- i_flash_miso  in  1  SPI data from flash

Behaviour:
- Reset values: o_flash_cs_n=1, o_flash_sclk=0, o_flash_mosi=0, o_busy=0, o_done=0, o_aborted=0, o_valid=0, o_data=0, FSM=IDLE.
- Reset asserted mid-job takes effect immediately; CS is released asynchronously.
- States and transitions:
  - IDLE -> CMD on i_start with i_len!=0. If i_len==0, the block stays in IDLE and pulses o_done the next cycle; CS never drops.
  - CMD (8 bits) -> ADDR (24 bits) -> DATA (8*len bits) -> CS_HOLD -> CS_GAP -> IDLE.
- i_start while busy is ignored.
- Edge timing (accepted start at cycle 0):
  - o_flash_cs_n falls at cycle 1; mosi = 0x03 bit7 at cycle 1.
  - Rising edge k (k=0..) at cycle 1+CLK_DIV+2*CLK_DIV*k; falling edge CLK_DIV cycles after each rise.
  - MOSI updates only on falling edges, MSB first.
  - MISO is sampled on the clk cycle of each rising edge.
  - MOSI = 0 during DATA.
- Byte j completes at rising edge k=32+8j+7. o_data and o_valid update on the following cycle.
- Handshake:
  - o_valid and o_data hold until o_valid&&i_ready; o_valid then drops the next cycle unless a new byte lands that same cycle.
  - A byte-completing rising edge is postponed while o_valid&&!i_ready. SCLK stays low and CS stays low, which is legal in mode 0. No byte is ever lost or overwritten.
- CS_HOLD:
  - Entered after the last byte's final falling edge, and only once the last byte has been accepted.
  - Lasts CLK_DIV cycles, then CS_n rises.
- CS_GAP:
  - CS_n high for 2*CLK_DIV cycles, o_busy still high.
  - o_done pulses in the last CS_GAP cycle; IDLE follows.
- Abort:
  - i_abort in any non-IDLE state drives sclk low next cycle, clears o_valid, and goes to CS_HOLD.
  - The job finishes with o_done and o_aborted both high.
  - Abort in IDLE has no effect.
- Counters:
  - Bit counter is 6 bits.
  - Remaining-byte counter is LEN_W bits; it decrements on byte completion and never wraps, since the terminal count is 0.
  - i_len of all-ones reads 2^LEN_W-1 bytes.
- Address wrap at the end of flash is the flash's behaviour; the block does not check it.

Decomposition:
- Package swervolf_flash_pkg: CMD_READ=8'h03, ADDR_BITS=24, CMD_BITS=8, state enum (IDLE, CMD, ADDR, DATA, CS_HOLD, CS_GAP).
- One sub-module, swervolf_spi_clkgen: CLK_DIV half-period counter producing o_sclk, rise_stb and fall_stb, with enable and stall inputs.
- The FSM and shift registers stay in swervolf_flash_reader.

Test Plan:
- CLK_DIV=2, start addr=0x000100, len=1, i_ready=1, flash model at 0x100 = 0xA5:
  - MOSI bits read 0x03,0x00,0x01,0x00.
  - o_valid=1 with o_data=0xA5 at cycle 160.
  - CS_n high at cycle 164; o_done pulses at cycle 168.
- len=4 from 0x000000 with i_ready held 0 for 50 cycles after each o_valid:
  - Exactly 4 bytes are delivered, in order.
  - SCLK is frozen low during each stall; CS_n stays low.
- start with len=0 -> o_done pulses at cycle 1; CS_n never falls; o_busy stays 0.
- i_abort during ADDR phase (cycle 60) -> sclk low at cycle 61; CS_n high 2 cycles later; o_done and o_aborted pulse; no o_valid is ever seen.
- i_start pulsed while busy -> ignored; the second job starts only after o_done; the CS_n-high gap is >=4 cycles.
- rstn pulsed low mid-DATA -> CS_n=1, sclk=0, o_valid=0 immediately; the next job runs correctly.
